// File: rtl/mux_8to1_pkg.sv
// ---------------------------------------------------------------------------
// mux_8to1_pkg
// Constants shared by the 8:1 multiplexer and anything that drives its select.
//   N_INPUTS : number of data inputs
//   SEL_W    : width of the select index (clog2 of N_INPUTS)
// ---------------------------------------------------------------------------
package mux_8to1_pkg;

  localparam int N_INPUTS = 8;
  localparam int SEL_W    = 3;

endpackage : mux_8to1_pkg

// File: rtl/mux_8to1.sv
// ---------------------------------------------------------------------------
// mux_8to1
// Eight-input multiplexer with a combinational output and a registered copy.
//
// Ports (in declaration order):
//   sel   in  [SEL_W-1:0]  select index 0..7
//   d7..d0 in [WIDTH-1:0]  data inputs, d<n> is chosen when sel == n
//   y     out [WIDTH-1:0]  selected data, zero-cycle latency
//   clk   in               clock for y_q
//   rst   in               asynchronous active-high clear of y_q
//   y_q   out [WIDTH-1:0]  y registered on the rising edge of clk
//
// The port order keeps legacy positional instances (sel, d7..d0, y) valid;
// clk, rst and y_q may simply be left unconnected by such users.
// ---------------------------------------------------------------------------
module mux_8to1
  import mux_8to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] d7,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] y,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] y_q
);

  logic [WIDTH-1:0] y_d;

  // Combinational select. A select carrying X/Z matches no item, so the
  // default propagates all-X in simulation; synthesis sees a don't-care.
  always_comb begin
    y_d = 'x;
    case (sel)
      3'd0:    y_d = d0;
      3'd1:    y_d = d1;
      3'd2:    y_d = d2;
      3'd3:    y_d = d3;
      3'd4:    y_d = d4;
      3'd5:    y_d = d5;
      3'd6:    y_d = d6;
      3'd7:    y_d = d7;
      default: y_d = 'x;
    endcase
  end

  assign y = y_d;

  // Output register: the only state in the block. Reset clears it at once,
  // independent of clk; the combinational path above is untouched by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

endmodule : mux_8to1

// File: tb/tb_mux_8to1.sv
module tb_mux_8to1;
  import mux_8to1_pkg::*;

  logic clk = 1'b0;
  logic rst;

  // 1-bit instance
  logic [SEL_W-1:0] sel1;
  logic             ad [N_INPUTS];
  logic             y1, y1_q;

  // 16-bit instance
  logic [SEL_W-1:0] sel16;
  logic [15:0]      bd [N_INPUTS];
  logic [15:0]      y16, y16_q;

  always #5 clk = ~clk;

  mux_8to1 #(.WIDTH(1)) dut1 (
    .sel(sel1),
    .d7(ad[7]), .d6(ad[6]), .d5(ad[5]), .d4(ad[4]),
    .d3(ad[3]), .d2(ad[2]), .d1(ad[1]), .d0(ad[0]),
    .y(y1), .clk(clk), .rst(rst), .y_q(y1_q)
  );

  mux_8to1 #(.WIDTH(16)) dut16 (
    .sel(sel16),
    .d7(bd[7]), .d6(bd[6]), .d5(bd[5]), .d4(bd[4]),
    .d3(bd[3]), .d2(bd[2]), .d1(bd[1]), .d0(bd[0]),
    .y(y16), .clk(clk), .rst(rst), .y_q(y16_q)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;   // data[i] drives d<i>
    logic       exp;
  } vec1_t;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] exp;
  } vec16_t;

  typedef struct {
    logic        e1;
    logic [15:0] e16;
  } sb_t;

  vec1_t  tab1  [64];
  vec16_t tab16 [8];
  sb_t    sbq   [$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pop the oldest expected registered value and compare both instances.
  task automatic sb_pop(input string nm);
    sb_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty got %h expected entry", nm, y16_q);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_q16"}, y16_q, e.e16);
      chk({nm, "_q1"}, {15'd0, y1_q}, {15'd0, e.e1});
    end
  endtask

  initial begin
    logic [15:0] ref16;
    logic        ref1;
    sb_t         e;

    // Tables: one-hot sweep for WIDTH=1, walking-one data for WIDTH=16.
    for (int p = 0; p < 8; p++) begin
      for (int s = 0; s < 8; s++) begin
        tab1[p*8+s].sel  = 3'(s);
        tab1[p*8+s].data = 8'h01 << p;
        tab1[p*8+s].exp  = (s == p);
      end
    end
    for (int s = 0; s < 8; s++) begin
      tab16[s].sel = 3'(s);
      tab16[s].exp = 16'h0001 << s;
    end

    // Reset state: y_q cleared before any clock edge.
    rst = 1'b1;
    sel1 = '0; sel16 = '0;
    for (int i = 0; i < N_INPUTS; i++) begin ad[i] = 1'b0; bd[i] = 16'h0; end
    #1;
    chk("reset_q16", y16_q, 16'h0000);
    chk("reset_q1", {15'd0, y1_q}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // One-hot sweep, WIDTH=1.
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 8; k++) ad[k] = tab1[i].data[k];
      sel1 = tab1[i].sel;
      #1;
      chk($sformatf("onehot_%0d", i), {15'd0, y1}, {15'd0, tab1[i].exp});
    end

    // Walking-one sweep, WIDTH=16.
    for (int k = 0; k < 8; k++) bd[k] = 16'h0001 << k;
    for (int i = 0; i < 8; i++) begin
      sel16 = tab16[i].sel;
      #1;
      chk($sformatf("walk16_sel%0d", i), y16, tab16[i].exp);
    end

    // sel=5: same-delta output, then one-cycle latency on y_q.
    @(negedge clk);
    sel16 = 3'd5;
    sel1  = 3'd7;
    #1;
    chk("sel5_y", y16, 16'h0020);
    e.e16 = 16'h0020; e.e1 = tab1[63].exp;  // ad still holds pattern 8'h80
    sbq.push_back(e);
    @(posedge clk); #1;
    sb_pop("sel5");

    // sel=3 held: unselected toggles leave y alone, selected one flows through.
    @(negedge clk);
    sel16 = 3'd3;
    #1;
    chk("hold3_base", y16, 16'h0008);
    bd[2] = 16'hA5A5; #1; chk("hold3_d2", y16, 16'h0008);
    bd[4] = 16'h5A5A; #1; chk("hold3_d4", y16, 16'h0008);
    bd[3] = 16'h1234; #1; chk("hold3_d3", y16, 16'h1234);
    bd[3] = 16'hFEDC; #1; chk("hold3_d3b", y16, 16'hFEDC);

    // Async reset between edges clears only y_q.
    @(negedge clk);
    bd[3] = 16'h00FF;
    @(posedge clk); #1;
    chk("pre_rst_q", y16_q, 16'h00FF);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_q", y16_q, 16'h0000);
    chk("rst_y_kept", y16, 16'h00FF);
    bd[3] = 16'h0F0F; #1;
    chk("rst_y_tracks", y16, 16'h0F0F);
    @(posedge clk); #1;
    chk("rst_held_q", y16_q, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rel_noedge", y16_q, 16'h0000);
    @(posedge clk); #1;
    chk("rst_rel_edge", y16_q, 16'h0F0F);

    // Unknown select gives all-X (4-state); a 2-state simulator collapses the
    // X bits, in which case y must match whatever index sel became.
    @(negedge clk);
    sel16 = 3'bx1x;
    #1;
    if ($isunknown(sel16)) chk("selx_y", y16, 16'hxxxx);
    else                   chk("selx_y2state", y16, bd[sel16]);
    sel16 = 3'd2;
    #1;
    chk("selx_restore", y16, 16'hA5A5);

    // Random traffic with scoreboarded registered output.
    sbq.delete();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      sel1  = 3'($urandom_range(0, 7));
      sel16 = 3'($urandom_range(0, 7));
      for (int k = 0; k < N_INPUTS; k++) begin
        ad[k] = 1'($urandom);
        bd[k] = 16'($urandom);
      end
      #1;
      ref16 = bd[sel16];
      ref1  = ad[sel1];
      chk("rand_y16", y16, ref16);
      chk("rand_y1", {15'd0, y1}, {15'd0, ref1});
      e.e16 = ref16; e.e1 = ref1;
      sbq.push_back(e);
      @(posedge clk); #1;
      sb_pop("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux_8to1
